dmem_responder: RTL
===================

# dmem_responder

Data-memory responder serving the CPU's load/store port through a valid/ready request channel and a valid/ready response channel. It holds a word-addressed RAM, inserts a configurable number of wait states, and checks alignment and range. Each transaction returns a response with read data or an error flag. It sits between the CPU datapath's load/store initiator and the storage array, so the core can be run against multi-cycle memory timing.

## Interface
- `DEPTH_WORDS`, 256, number of 32-bit words; must be a power of two ≥ 4.
- `LATENCY`, 2, wait cycles between acceptance and response, range 0–15.
- `clk`  in  1  clock, all state changes on the rising edge.
- `rst`  in  1  reset. One clock; reset is synchronous and active-high.
- `req_valid`  in  1  request present.
- `req_ready`  out  1  responder can accept a request.
- `req_write`  in  1  1 = store, 0 = load.
- `req_addr`  in  32  byte address.
- `req_wdata`  in  32  store data.
- `req_be`  in  4  byte enables for stores; bit i covers bits [8i+7:8i].
- `rsp_valid`  out  1  response present.
- `rsp_ready`  in  1  initiator accepts the response.
- `rsp_rdata`  out  32  load data; 0 for stores and errors.
- `rsp_err`  out  1  request was misaligned or out of range.

## Operation
- FSM states:
  - IDLE: `req_ready` = 1.
  - WAIT: counts wait states.
  - RESP: `rsp_valid` = 1.
- `req_ready` = (state == IDLE) && !`rst`. It is combinational from the state.
- IDLE:
  - On `req_valid` && `req_ready`, capture `req_write`, `req_addr`, `req_wdata` and `req_be`.
  - If `LATENCY` = 0, go to RESP. Otherwise load the counter with `LATENCY`−1 and go to WAIT.
- WAIT: when the counter is 0, go to RESP; otherwise decrement it.
- Transaction commit happens on the edge that enters RESP:
  - Error check: `rsp_err` = (addr[1:0] ≠ 0) || (addr[31:log2(DEPTH_WORDS)+2] ≠ 0).
  - Word index = addr[log2(DEPTH_WORDS)+1:2].
  - Store without error: write the enabled bytes to the array. `rsp_rdata` = 0.
  - Load without error: `rsp_rdata` = array word.
  - Any error: no array write, `rsp_rdata` = 0.
- RESP:
  - `rsp_valid`, `rsp_rdata` and `rsp_err` stay stable while `rsp_ready` = 0.
  - On `rsp_ready`, go to IDLE and clear `rsp_valid`, `rsp_rdata` and `rsp_err`.
- A new request is never accepted in the same cycle as a response handshake. Inputs are ignored outside IDLE.
- The array is not cleared by reset. Its contents are undefined until written.

## Timing
- Reset values: state IDLE, `req_ready` = 0 while `rst` = 1 and 1 from the first cycle after. `rsp_valid` = 0, `rsp_rdata` = 0, `rsp_err` = 0, counter = 0.
- Request accepted at edge E:
  - `rsp_valid` rises after edge E+`LATENCY`+... specifically it is visible in the cycle after edge E+`LATENCY`.
  - With `LATENCY` = 0, it is visible in the cycle after E.
- Best-case throughput with `rsp_ready` held at 1 is one transaction per `LATENCY`+2 cycles.
- Reset mid-transaction:
  - Abort and return to IDLE.
  - A pending store that has not reached its commit edge is not written.
  - Any response is dropped.
- Store-then-load to the same word: the load returns the new data, because the write has committed before the load is accepted.

## Configuration
- `DMEM_BYTE_ENABLE_EN` defined:
  - `req_be` masks store bytes as described.
  - A store with `req_be` = 0 is legal. It writes nothing and responds normally.
- Not defined:
  - `req_be` is ignored.
  - Every error-free store writes all 32 bits.

## Test plan
- Reset, then store 0xDEADBEEF to 0x10, then load 0x10 with `LATENCY` = 2 and `rsp_ready` = 1:
  - Each `rsp_valid` appears 3 cycles after acceptance.
  - The load returns 0xDEADBEEF with `rsp_err` = 0.
- With `DMEM_BYTE_ENABLE_EN`:
  - Store 0x11223344 to 0x20 with `be` = 4'hF, then 0xAABBCCDD with `be` = 4'b0101.
  - A load of 0x20 returns 0x11BB33DD.
- Without the macro, the same sequence returns 0xAABBCCDD.
- Store to 0x22 (misaligned), then to 0x400 with `DEPTH_WORDS` = 256 (out of range):
  - Both give `rsp_err` = 1 and `rsp_rdata` = 0.
  - A subsequent load of 0x0 is unchanged.
- Hold `rsp_ready` = 0 for 5 cycles during a load response:
  - `rsp_valid`, `rsp_rdata` and `rsp_err` stay constant.
  - `req_ready` = 0 throughout.
  - The response clears on the cycle after `rsp_ready` = 1.
- Accept a store to 0x30 (initially 0x0), then assert `rst` during WAIT:
  - Outputs return to reset values.
  - A load of 0x30 after reset returns 0x0.
- With `LATENCY` = 0, issue back-to-back loads with `req_valid` held high:
  - `rsp_valid` appears 1 cycle after each acceptance.
  - Acceptances are 2 cycles apart.

Source files
------------

// File: rtl/dmem_responder.sv
// Data-memory responder: word RAM behind valid/ready request/response channels with fixed wait states.
// Optional DMEM_BYTE_ENABLE_EN: honour req_be on stores; otherwise stores write the full word.
module dmem_responder #(
    parameter int DEPTH_WORDS = 256,
    parameter int LATENCY     = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [3:0]  req_be,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err
);
    localparam int AW = $clog2(DEPTH_WORDS);
    localparam logic [3:0] LOAD_CNT = (LATENCY == 0) ? 4'd0 : 4'(LATENCY - 1);

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t      state;
    logic [3:0]  cnt;
    logic        cap_write;
    logic [31:0] cap_addr;
    logic [31:0] cap_wdata;
    logic [3:0]  cap_be;
    logic [31:0] mem [DEPTH_WORDS];

    logic          sel_write;
    logic [31:0]   sel_addr;
    logic [31:0]   sel_wdata;
    logic [3:0]    sel_be;
    logic [3:0]    wr_be;
    logic          accept;
    logic          commit;
    logic          addr_err;
    logic [AW-1:0] idx;

    assign req_ready = (state == IDLE) && !rst;
    assign accept    = (state == IDLE) && req_valid;

    // With zero latency the commit edge is the accept edge, so the live request feeds the commit path.
    always_comb begin
        sel_write = cap_write;
        sel_addr  = cap_addr;
        sel_wdata = cap_wdata;
        sel_be    = cap_be;
        if (state == IDLE) begin
            sel_write = req_write;
            sel_addr  = req_addr;
            sel_wdata = req_wdata;
            sel_be    = req_be;
        end
    end

    assign commit   = (LATENCY == 0) ? accept : ((state == WAIT) && (cnt == 4'd0));
    assign addr_err = (sel_addr[1:0] != 2'b00) || (sel_addr[31:AW+2] != '0);
    assign idx      = sel_addr[AW+1:2];

`ifdef DMEM_BYTE_ENABLE_EN
    assign wr_be = sel_be;
`else
    assign wr_be = 4'hF;
    wire unused_be = &{1'b0, sel_be};
`endif

    // Array has no reset; rst only blocks a commit landing on the same edge.
    always_ff @(posedge clk) begin
        if (!rst && commit && sel_write && !addr_err) begin
            for (int b = 0; b < 4; b++) begin
                if (wr_be[b]) mem[idx][8*b +: 8] <= sel_wdata[8*b +: 8];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= 4'd0;
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
            cap_write <= 1'b0;
            cap_addr  <= '0;
            cap_wdata <= '0;
            cap_be    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        cap_write <= req_write;
                        cap_addr  <= req_addr;
                        cap_wdata <= req_wdata;
                        cap_be    <= req_be;
                        if (LATENCY == 0) begin
                            state <= RESP;
                        end else begin
                            cnt   <= LOAD_CNT;
                            state <= WAIT;
                        end
                    end
                end
                WAIT: begin
                    if (cnt == 4'd0) state <= RESP;
                    else             cnt   <= cnt - 4'd1;
                end
                RESP: begin
                    if (rsp_ready) begin
                        state     <= IDLE;
                        rsp_valid <= 1'b0;
                        rsp_rdata <= '0;
                        rsp_err   <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
            if (commit) begin
                rsp_valid <= 1'b1;
                rsp_err   <= addr_err;
                rsp_rdata <= (!sel_write && !addr_err) ? mem[idx] : '0;
            end
        end
    end
endmodule
